// File: rtl/tx_sched_pkg.sv
// tx_send_scheduler shared types: FSM state enum, default parameters
// and the MAC-side end-of-packet handshake test.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_WAIT_EOP,
    S_GAP
  } tx_sched_state_t;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_ADDR_W      = 25;
  localparam int DEF_CMD_HI_CYC  = 2;
  localparam int DEF_GAP_CYC     = 12;
  localparam int DEF_TIMEOUT_CYC = 4096;

  function automatic logic eop_handshake(
    input logic wren,
    input logic eop,
    input logic rdy
  );
    return wren & eop & rdy;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: lowest requesting index at or
// above ptr, else lowest overall. Ports: req, ptr -> gnt_onehot, gnt_idx, any.
module rr_arbiter
  import tx_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IW-1:0]      gnt_idx,
  output logic               any
);

  logic found;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (IW'(i) >= ptr)) begin
        gnt_idx = IW'(i);
        found   = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        gnt_idx = IW'(i);
        found   = 1'b1;
      end
    end
  end

  assign any = |req;
  assign gnt_onehot = any
    ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx)
    : '0;

endmodule

// File: rtl/tx_send_scheduler.sv
// Round-robin scheduler sharing send_packet among NUM_REQ producers.
// Ports: req_valid/req_addr/req_ready, cmd_send/start_ram_addr, mon_tx_*, status.
module tx_send_scheduler
  import tx_sched_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int CMD_HI_CYC  = DEF_CMD_HI_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                      clk_original,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cmd_send,
  output logic [ADDR_W-1:0]         start_ram_addr,
  input  logic                      mon_tx_wren,
  input  logic                      mon_tx_eop,
  input  logic                      mon_tx_rdy,
  output logic                      busy,
  output logic [IW-1:0]             grant_id,
  output logic                      done_pulse,
  output logic                      timeout_pulse,
  output logic [15:0]               pkt_count
);

  localparam int CW = $clog2(CMD_HI_CYC) + 1;
  localparam int GW = $clog2(GAP_CYC) + 1;
  localparam int WW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_HI_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

  tx_sched_state_t state_q, state_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               cmd_send_q, cmd_send_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               busy_q, busy_d;
  logic [IW-1:0]      grant_id_q, grant_id_d;
  logic               done_q, done_d;
  logic               to_q, to_d;
  logic [15:0]        pkt_q, pkt_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      cmd_cnt_q, cmd_cnt_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [WW-1:0]      wd_cnt_q, wd_cnt_d;

  logic [NUM_REQ-1:0] gnt_onehot;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .gnt_onehot(gnt_onehot),
    .gnt_idx   (gnt_idx),
    .any       (gnt_any)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_d = '0;
    cmd_send_d  = cmd_send_q;
    addr_d      = addr_q;
    grant_id_d  = grant_id_q;
    done_d      = 1'b0;
    to_d        = 1'b0;
    pkt_d       = pkt_q;
    rr_ptr_d    = rr_ptr_q;
    cmd_cnt_d   = cmd_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          state_d     = S_CMD;
          addr_d      = req_addr[gnt_idx*ADDR_W +: ADDR_W];
          grant_id_d  = gnt_idx;
          req_ready_d = gnt_onehot;
          cmd_send_d  = 1'b1;
          cmd_cnt_d   = '0;
          rr_ptr_d    = (gnt_idx == IW'(NUM_REQ - 1))
                      ? '0 : gnt_idx + IW'(1);
        end
      end
      S_CMD: begin
        if (cmd_cnt_q == CMD_LAST) begin
          state_d    = S_WAIT_EOP;
          cmd_send_d = 1'b0;
          wd_cnt_d   = '0;
        end else begin
          cmd_cnt_d = cmd_cnt_q + CW'(1);
        end
      end
      S_WAIT_EOP: begin
        // completion is tested first so it wins over a same-cycle expiry
        if (eop_handshake(mon_tx_wren, mon_tx_eop, mon_tx_rdy)) begin
          done_d  = 1'b1;
          pkt_d   = pkt_q + 16'd1;
          state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
        end else if (wd_cnt_q == WD_LAST) begin
          to_d    = 1'b1;
          state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
        end else begin
          wd_cnt_d = wd_cnt_q + WW'(1);
        end
        gap_cnt_d = '0;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_original) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= '0;
      cmd_send_q  <= 1'b0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      grant_id_q  <= '0;
      done_q      <= 1'b0;
      to_q        <= 1'b0;
      pkt_q       <= '0;
      rr_ptr_q    <= '0;
      cmd_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      wd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      cmd_send_q  <= cmd_send_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      grant_id_q  <= grant_id_d;
      done_q      <= done_d;
      to_q        <= to_d;
      pkt_q       <= pkt_d;
      rr_ptr_q    <= rr_ptr_d;
      cmd_cnt_q   <= cmd_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign cmd_send       = cmd_send_q;
  assign start_ram_addr = addr_q;
  assign busy           = busy_q;
  assign grant_id       = grant_id_q;
  assign done_pulse     = done_q;
  assign timeout_pulse  = to_q;
  assign pkt_count      = pkt_q;

endmodule

// File: tb/tb_tx_send_scheduler.sv
// Self-checking bench for tx_send_scheduler: cycle-vector table plus
// directed sequences for fairness, timeout, simultaneous events, reset.
module tb_tx_send_scheduler;

  localparam int N  = 4;
  localparam int AW = 25;
  localparam int CH = 2;
  localparam int GP = 12;
  localparam int TO = 64;

  logic              clk_original = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      req_ready;
  logic              cmd_send;
  logic [AW-1:0]     start_ram_addr;
  logic              mon_tx_wren = 1'b0;
  logic              mon_tx_eop = 1'b0;
  logic              mon_tx_rdy = 1'b0;
  logic              busy;
  logic [1:0]        grant_id;
  logic              done_pulse;
  logic              timeout_pulse;
  logic [15:0]       pkt_count;

  tx_send_scheduler #(
    .NUM_REQ(N), .ADDR_W(AW), .CMD_HI_CYC(CH),
    .GAP_CYC(GP), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_original  (clk_original),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .cmd_send      (cmd_send),
    .start_ram_addr(start_ram_addr),
    .mon_tx_wren   (mon_tx_wren),
    .mon_tx_eop    (mon_tx_eop),
    .mon_tx_rdy    (mon_tx_rdy),
    .busy          (busy),
    .grant_id      (grant_id),
    .done_pulse    (done_pulse),
    .timeout_pulse (timeout_pulse),
    .pkt_count     (pkt_count)
  );

  always #5 clk_original = ~clk_original;

  int n_chk = 0;
  int n_err = 0;

  logic [AW-1:0] addr_of [N];

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        w, e, r;
    logic [3:0]  x_rdy;
    logic        x_cmd, x_busy, x_done, x_to;
    logic [15:0] x_pkt;
    logic [24:0] x_addr;
    logic [1:0]  x_gid;
  } vec_t;

  vec_t tv [18];

  function automatic vec_t mk(
    input logic rs, input logic [3:0] rq,
    input logic w, input logic e, input logic r,
    input logic [3:0] xr, input logic xc, input logic xb,
    input logic xd, input logic xt, input logic [15:0] xp,
    input logic [24:0] xa, input logic [1:0] xg
  );
    vec_t v;
    v.rst = rs; v.req = rq; v.w = w; v.e = e; v.r = r;
    v.x_rdy = xr; v.x_cmd = xc; v.x_busy = xb;
    v.x_done = xd; v.x_to = xt; v.x_pkt = xp;
    v.x_addr = xa; v.x_gid = xg;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_original);
    #1;
  endtask

  function automatic logic [50:0] snap();
    return {req_ready, cmd_send, busy, done_pulse, timeout_pulse,
            pkt_count, start_ram_addr, grant_id};
  endfunction

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk(nm, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int g, last, cyc, n;
    logic saw_done, saw_any;

    addr_of[0] = 25'h0001000;
    addr_of[1] = 25'h002A5A5;
    addr_of[2] = 25'h0000040;
    addr_of[3] = 25'h1FFFFFF;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_of[i];

    // single request from reset, masked eop, eop ignored in gap
    tv[0] = mk(1, 4'b0000, 0,0,0, 4'b0000, 0,0,0,0, 16'd0, 25'h0,  2'd0);
    tv[1] = mk(0, 4'b0100, 0,0,0, 4'b0100, 1,1,0,0, 16'd0, 25'h40, 2'd2);
    tv[2] = mk(0, 4'b0000, 0,0,0, 4'b0000, 1,1,0,0, 16'd0, 25'h40, 2'd2);
    tv[3] = mk(0, 4'b0000, 0,0,0, 4'b0000, 0,1,0,0, 16'd0, 25'h40, 2'd2);
    tv[4] = mk(0, 4'b0000, 1,1,0, 4'b0000, 0,1,0,0, 16'd0, 25'h40, 2'd2);
    tv[5] = mk(0, 4'b0000, 1,1,1, 4'b0000, 0,1,1,0, 16'd1, 25'h40, 2'd2);
    tv[6] = mk(0, 4'b0000, 1,1,1, 4'b0000, 0,1,0,0, 16'd1, 25'h40, 2'd2);
    for (int i = 7; i < 17; i++)
      tv[i] = mk(0, 4'b0000, 0,0,0, 4'b0000, 0,1,0,0, 16'd1, 25'h40, 2'd2);
    tv[17] = mk(0, 4'b0000, 0,0,0, 4'b0000, 0,0,0,0, 16'd1, 25'h40, 2'd2);

    for (int i = 0; i < 18; i++) begin
      rst = tv[i].rst;
      req_valid = tv[i].req;
      mon_tx_wren = tv[i].w;
      mon_tx_eop = tv[i].e;
      mon_tx_rdy = tv[i].r;
      step();
      chk($sformatf("vec%0d", i), {13'd0, snap()},
          {13'd0, tv[i].x_rdy, tv[i].x_cmd, tv[i].x_busy,
           tv[i].x_done, tv[i].x_to, tv[i].x_pkt,
           tv[i].x_addr, tv[i].x_gid});
    end

    // fairness: all request continuously, eop always offered
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    mon_tx_wren = 1'b1; mon_tx_eop = 1'b1; mon_tx_rdy = 1'b1;
    g = 0; last = 0; cyc = 0;
    while (g < 6 && cyc < 200) begin
      step();
      cyc++;
      if (req_ready != 0) begin
        chk($sformatf("fair_gnt%0d", g), {60'd0, req_ready},
            64'd1 << (g % 4));
        chk($sformatf("fair_addr%0d", g), {39'd0, start_ram_addr},
            {39'd0, addr_of[g % 4]});
        if (g > 0)
          chk($sformatf("fair_gap%0d", g), cyc - last, CH + 1 + GP + 1);
        last = cyc;
        g++;
      end
    end
    chk("fair_count", g, 6);
    chk("fair_pkt5", {48'd0, pkt_count}, 64'd5);
    req_valid = '0;
    wait_idle("fair_idle");
    chk("fair_pkt6", {48'd0, pkt_count}, 64'd6);

    // timeout: rr_ptr now 2; requesters 1 and 2 ask, 2 wins
    mon_tx_eop = 1'b0;
    req_valid = 4'b0110;
    step();
    chk("to_gnt", {60'd0, req_ready}, 64'b0100);
    req_valid = 4'b0010;
    n = 0; saw_done = 1'b0;
    while (!timeout_pulse && n < 100) begin
      step();
      n++;
      if (done_pulse) saw_done = 1'b1;
    end
    chk("to_latency", n, CH + TO);
    chk("to_no_done", {63'd0, saw_done}, 64'd0);
    chk("to_pkt", {48'd0, pkt_count}, 64'd6);
    n = 0;
    while (req_ready == 0 && n < 40) begin
      step();
      n++;
    end
    chk("to_next_lat", n, GP + 1);
    chk("to_next_gnt", {60'd0, req_ready}, 64'b0010);
    req_valid = '0;

    // completion on the very cycle the watchdog expires
    saw_any = 1'b0;
    for (int i = 1; i <= CH + TO - 1; i++) begin
      step();
      if (done_pulse || timeout_pulse) saw_any = 1'b1;
    end
    chk("sim_quiet", {63'd0, saw_any}, 64'd0);
    mon_tx_eop = 1'b1;
    step();
    chk("sim_done_to", {62'd0, done_pulse, timeout_pulse}, 64'b10);
    chk("sim_pkt", {48'd0, pkt_count}, 64'd7);
    mon_tx_eop = 1'b0;
    wait_idle("sim_idle");

    // reset in WAIT_EOP after granting requester 2 (rr_ptr -> 3)
    req_valid = 4'b0100;
    step();
    chk("rst_pre_gnt", {60'd0, req_ready}, 64'b0100);
    req_valid = '0;
    for (int i = 0; i < 4; i++) step();
    chk("rst_pre_busy", {62'd0, busy, cmd_send}, 64'b10);
    rst = 1'b1;
    step();
    chk("rst_vals", {13'd0, snap()}, 64'd0);
    rst = 1'b0;
    req_valid = 4'b1010;
    step();
    chk("rst_next_gnt", {60'd0, req_ready}, 64'b0010);
    chk("rst_next_id", {62'd0, grant_id}, 64'd1);
    chk("rst_next_addr", {39'd0, start_ram_addr}, {39'd0, addr_of[1]});
    req_valid = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
